// File: rtl/bcd_to_binary_seq_if.sv
// Request/response bundle of the sequential BCD-to-binary converter.
// The master issues start with three BCD digits; the slave returns the handshake and result.
interface bcd_to_binary_seq_if;
    logic       start;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;
    logic       done;
    logic [7:0] value;
    logic       overflow;
    logic       error;

    modport master (
        output start, hundreds, tens, ones,
        input  busy, done, value, overflow, error
    );

    modport slave (
        input  start, hundreds, tens, ones,
        output busy, done, value, overflow, error
    );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double dabble, one shift per clock.
// Three BCD digits in, saturated 8-bit binary out, with invalid-digit and overflow flags.
module bcd_to_binary_seq (
    input  logic                clk_50MHz,
    input  logic                reset,
    bcd_to_binary_seq_if.slave  bus
);
    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned N_DIGITS = 3;
    localparam int unsigned BCD_W    = DIGIT_W * N_DIGITS;
    localparam int unsigned BIN_W    = 10;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned VALUE_W  = 8;

    localparam logic [CNT_W-1:0]   LAST_SHIFT = CNT_W'(9);
    localparam logic [DIGIT_W-1:0] MAX_DIGIT  = DIGIT_W'(9);
    localparam logic [DIGIT_W-1:0] ADJ_LIMIT  = DIGIT_W'(8);
    localparam logic [DIGIT_W-1:0] ADJ_STEP   = DIGIT_W'(3);
    localparam logic [BIN_W-1:0]   MAX_VALUE  = BIN_W'(255);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [BCD_W-1:0]     bcd_reg, bcd_nxt;
    logic [BIN_W-1:0]     bin_reg, bin_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 err, err_nxt;
    logic                 busy_nxt, done_nxt;
    logic [VALUE_W-1:0]   value_nxt;
    logic                 overflow_nxt, error_nxt;
    logic                 digits_ok;
    logic [BCD_W-1:0]     bcd_shifted;
    logic [BIN_W-1:0]     bin_shifted;

    // State and registered outputs
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state        <= IDLE;
            bcd_reg      <= '0;
            bin_reg      <= '0;
            cnt          <= '0;
            err          <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.value    <= '0;
            bus.overflow <= 1'b0;
            bus.error    <= 1'b0;
        end else begin
            state        <= state_nxt;
            bcd_reg      <= bcd_nxt;
            bin_reg      <= bin_nxt;
            cnt          <= cnt_nxt;
            err          <= err_nxt;
            bus.busy     <= busy_nxt;
            bus.done     <= done_nxt;
            bus.value    <= value_nxt;
            bus.overflow <= overflow_nxt;
            bus.error    <= error_nxt;
        end
    end

    // Next-state, datapath step and output values
    always_comb begin
        state_nxt    = state;
        bcd_nxt      = bcd_reg;
        bin_nxt      = bin_reg;
        cnt_nxt      = cnt;
        err_nxt      = err;
        done_nxt     = 1'b0;
        value_nxt    = bus.value;
        overflow_nxt = bus.overflow;
        error_nxt    = bus.error;

        digits_ok = (bus.hundreds <= MAX_DIGIT) && (bus.tens <= MAX_DIGIT)
                    && (bus.ones <= MAX_DIGIT);
        {bcd_shifted, bin_shifted} = {bcd_reg, bin_reg} >> 1;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (digits_ok) begin
                        bcd_nxt   = {bus.hundreds, bus.tens, bus.ones};
                        bin_nxt   = '0;
                        cnt_nxt   = '0;
                        err_nxt   = 1'b0;
                        state_nxt = CONVERT;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            CONVERT: begin
                bin_nxt = bin_shifted;
                // Undo the doubling carried into each digit by the shift
                for (int unsigned i = 0; i < N_DIGITS; i++) begin
                    if (bcd_shifted[i*DIGIT_W +: DIGIT_W] >= ADJ_LIMIT)
                        bcd_nxt[i*DIGIT_W +: DIGIT_W] = bcd_shifted[i*DIGIT_W +: DIGIT_W] - ADJ_STEP;
                    else
                        bcd_nxt[i*DIGIT_W +: DIGIT_W] = bcd_shifted[i*DIGIT_W +: DIGIT_W];
                end
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == LAST_SHIFT)
                    state_nxt = DONE;
            end
            DONE: begin
                done_nxt = 1'b1;
                if (err) begin
                    value_nxt    = '0;
                    overflow_nxt = 1'b0;
                    error_nxt    = 1'b1;
                end else if (bin_reg > MAX_VALUE) begin
                    value_nxt    = '1;
                    overflow_nxt = 1'b1;
                    error_nxt    = 1'b0;
                end else begin
                    value_nxt    = bin_reg[VALUE_W-1:0];
                    overflow_nxt = 1'b0;
                    error_nxt    = 1'b0;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed self-checking bench for bcd_to_binary_seq: vector table plus
// hand-written sequences for busy/latching, mid-operation reset and back-to-back requests.
module tb_bcd_to_binary_seq;
    logic clk_50MHz = 1'b0;
    logic reset;

    bcd_to_binary_seq_if bus ();

    bcd_to_binary_seq dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .bus       (bus.slave)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    typedef struct {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic [7:0] val;
        logic       ovf;
        logic       err;
        int         lat;
    } vec_t;

    localparam int N_VECS = 12;
    vec_t vecs [N_VECS];

    int n_checks = 0;
    int n_fail   = 0;
    int prev_val = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_50MHz);
        #1;
    endtask

    // One request: pulse start, wait for done, compare latency, busy window and result
    task automatic run_vec(input vec_t v, input string nm);
        int  n;
        int  busy_cnt;
        bit  seen;
        bus.start    = 1'b1;
        bus.hundreds = v.h;
        bus.tens     = v.t;
        bus.ones     = v.o;
        tick();
        bus.start = 1'b0;
        chk({nm, "_busy_at_accept"}, int'(bus.busy), 1);
        chk({nm, "_value_held"}, int'(bus.value), prev_val);
        n = 0;
        busy_cnt = 1;
        seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_cnt++;
        end
        chk({nm, "_done_seen"}, int'(seen), 1);
        chk({nm, "_latency"}, n, v.lat);
        chk({nm, "_busy_cycles"}, busy_cnt, v.lat);
        chk({nm, "_value"}, int'(bus.value), int'(v.val));
        chk({nm, "_overflow"}, int'(bus.overflow), int'(v.ovf));
        chk({nm, "_error"}, int'(bus.error), int'(v.err));
        chk({nm, "_busy_at_done"}, int'(bus.busy), 0);
        tick();
        chk({nm, "_done_single"}, int'(bus.done), 0);
        prev_val = int'(v.val);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_busy"}, int'(bus.busy), 0);
        chk({nm, "_done"}, int'(bus.done), 0);
        chk({nm, "_value"}, int'(bus.value), 0);
        chk({nm, "_overflow"}, int'(bus.overflow), 0);
        chk({nm, "_error"}, int'(bus.error), 0);
    endtask

    initial begin
        vec_t v;
        int   n;
        int   last;
        int   ndone;
        bit   prev_done;
        bit   seen;

        //          h      t      o      val     ovf   err   lat
        vecs[0]  = '{4'd0, 4'd4,  4'd2,  8'd42,  1'b0, 1'b0, 11};
        vecs[1]  = '{4'd2, 4'd5,  4'd5,  8'd255, 1'b0, 1'b0, 11};
        vecs[2]  = '{4'd2, 4'd5,  4'd6,  8'hFF,  1'b1, 1'b0, 11};
        vecs[3]  = '{4'd9, 4'd9,  4'd9,  8'hFF,  1'b1, 1'b0, 11};
        vecs[4]  = '{4'd0, 4'd0,  4'd0,  8'd0,   1'b0, 1'b0, 11};
        vecs[5]  = '{4'd0, 4'd10, 4'd3,  8'd0,   1'b0, 1'b1, 1};
        vecs[6]  = '{4'd0, 4'd9,  4'd9,  8'd99,  1'b0, 1'b0, 11};
        vecs[7]  = '{4'd1, 4'd9,  4'd9,  8'd199, 1'b0, 1'b0, 11};
        vecs[8]  = '{4'd15,4'd0,  4'd0,  8'd0,   1'b0, 1'b1, 1};
        vecs[9]  = '{4'd1, 4'd2,  4'd8,  8'd128, 1'b0, 1'b0, 11};
        vecs[10] = '{4'd0, 4'd0,  4'd12, 8'd0,   1'b0, 1'b1, 1};
        vecs[11] = '{4'd3, 4'd0,  4'd0,  8'hFF,  1'b1, 1'b0, 11};

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.hundreds = 4'd0;
        bus.tens     = 4'd0;
        bus.ones     = 4'd0;
        tick();
        tick();
        chk_reset_outputs("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < N_VECS; i++) begin
            v = vecs[i];
            run_vec(v, $sformatf("vec%0d", i));
        end

        // Busy and latching: start 1,2,3, re-request 0,0,7 on cycle 5, scramble digits
        bus.start = 1'b1;
        bus.hundreds = 4'd1; bus.tens = 4'd2; bus.ones = 4'd3;
        tick();
        bus.start = 1'b0;
        bus.hundreds = 4'd9; bus.tens = 4'd9; bus.ones = 4'd9;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            if (n == 4) begin
                bus.start = 1'b1;
                bus.hundreds = 4'd0; bus.tens = 4'd0; bus.ones = 4'd7;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            n++;
            if (n == 6) begin
                bus.hundreds = 4'd5; bus.tens = 4'd15; bus.ones = 4'd1;
            end
            if (bus.done) seen = 1'b1;
        end
        chk("latch_latency", n, 11);
        chk("latch_value", int'(bus.value), 123);
        chk("latch_error", int'(bus.error), 0);
        bus.start = 1'b0;
        tick();
        tick();
        chk("latch_no_queued_busy", int'(bus.busy), 0);
        prev_val = 123;

        // Reset in the middle of a conversion of 1,0,0
        bus.start = 1'b1;
        bus.hundreds = 4'd1; bus.tens = 4'd0; bus.ones = 4'd0;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk_reset_outputs("midreset");
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        chk("midreset_no_done", int'(seen), 0);
        prev_val = 0;
        v = '{4'd0, 4'd1, 4'd7, 8'd17, 1'b0, 1'b0, 11};
        run_vec(v, "after_reset");

        // Back-to-back: start held high; 11-cycle latency plus the accepting IDLE cycle
        bus.start = 1'b1;
        bus.hundreds = 4'd0; bus.tens = 4'd5; bus.ones = 4'd0;
        last = 0;
        ndone = 0;
        prev_done = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.done) begin
                chk($sformatf("b2b_value%0d", ndone), int'(bus.value), 50);
                chk($sformatf("b2b_spacing%0d", ndone), c - last, 12);
                chk($sformatf("b2b_done_run%0d", ndone), int'(prev_done), 0);
                last = c;
                ndone++;
            end
            prev_done = bus.done;
        end
        bus.start = 1'b0;
        chk("b2b_count", ndone, 3);
        repeat (15) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
